proc_run_ctrl: RTL and testbench

//  Hardware run sequencer for the singlecycle processor. Holds the core in reset, loads a start PC,

---
 rtl/proc_run_ctrl.sv | 130 +++++++++++++
 tb/tb_proc_run_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/proc_run_ctrl.sv
// Run sequencer for the single-cycle core: reset, release, watch for the halt PC,
// settle one cycle, then compare the data-memory word against a pass code.
module proc_run_ctrl #(
    parameter int RST_CYCLES = 1,
    parameter int MAX_CYCLES = 255,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [63:0]      start_pc,
    input  logic [63:0]      halt_pc,
    input  logic [63:0]      expected,
    input  logic [63:0]      currentpc,
    input  logic [63:0]      dmemout,
    output logic             proc_resetl,
    output logic [63:0]      proc_startpc,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_RUN, S_DRAIN, S_CHECK, S_DONE
    } state_t;

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           state, state_d;
    logic [RCW-1:0]   rst_cnt, rst_cnt_d;
    logic [63:0]      halt_q, halt_d, expected_q, expected_d, startpc_d;
    logic             pass_d, timeout_d;
    logic [CNT_W-1:0] count_d;
    logic             active;

    assign active = (state == S_RESET) || (state == S_RUN) ||
                    (state == S_DRAIN) || (state == S_CHECK);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d    = state;
        rst_cnt_d  = rst_cnt;
        halt_d     = halt_q;
        expected_d = expected_q;
        startpc_d  = proc_startpc;
        pass_d     = pass;
        timeout_d  = timeout;
        count_d    = cycle_count;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RESET;
                    rst_cnt_d  = '0;
                    halt_d     = halt_pc;
                    expected_d = expected;
                    startpc_d  = start_pc;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    count_d    = '0;
                end
            end
            S_RESET: begin
                if (rst_cnt == RST_LAST) state_d = S_RUN;
                else                     rst_cnt_d = rst_cnt + RCW'(1);
            end
            S_RUN: begin
                if (cycle_count != CNT_MAX) count_d = cycle_count + CNT_W'(1);
                // Halt is tested first so a halt on the last budgeted cycle still counts.
                if (currentpc >= halt_q) begin
                    state_d = S_DRAIN;
                end else if (cycle_count == CNT_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            S_DRAIN: state_d = S_CHECK;
            S_CHECK: begin
                pass_d  = (dmemout == expected_q);
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && active) begin
            state_d   = S_IDLE;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rst_cnt      <= '0;
            halt_q       <= '0;
            expected_q   <= '0;
            proc_startpc <= '0;
            proc_resetl  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state        <= state_d;
            rst_cnt      <= rst_cnt_d;
            halt_q       <= halt_d;
            expected_q   <= expected_d;
            proc_startpc <= startpc_d;
            proc_resetl  <= (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_CHECK);
            busy         <= (state_d == S_RESET) || (state_d == S_RUN) ||
                            (state_d == S_DRAIN) || (state_d == S_CHECK);
            done         <= (state_d == S_DONE);
            pass         <= pass_d;
            timeout      <= timeout_d;
            cycle_count  <= count_d;
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl: directed and random runs against a
// run-outcome model that walks the PC trajectory of a simple stepping core.
module tb_proc_run_ctrl;

    localparam int R   = 3;
    localparam int MAX = 255;

    logic        CLK = 1'b0;
    logic        reset, start, abort;
    logic [63:0] start_pc, halt_pc, expected, currentpc, dmemout;
    logic        proc_resetl, busy, done, pass, timeout;
    logic [63:0] proc_startpc;
    logic [15:0] cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    proc_run_ctrl #(.RST_CYCLES(R), .MAX_CYCLES(MAX), .CNT_W(16)) dut (
        .CLK(CLK), .reset(reset), .start(start), .abort(abort),
        .start_pc(start_pc), .halt_pc(halt_pc), .expected(expected),
        .currentpc(currentpc), .dmemout(dmemout),
        .proc_resetl(proc_resetl), .proc_startpc(proc_startpc),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".resetl"}, 64'(proc_resetl), 0);
        check({tag, ".startpc"}, proc_startpc, 0);
        check({tag, ".busy"}, 64'(busy), 0);
        check({tag, ".done"}, 64'(done), 0);
        check({tag, ".pass"}, 64'(pass), 0);
        check({tag, ".timeout"}, 64'(timeout), 0);
        check({tag, ".count"}, 64'(cycle_count), 0);
    endtask

    // One run. The core model starts at spc when released and advances by step
    // each RUN cycle. abort_k / sneak_k / reset_k (0 = off) act in that RUN cycle.
    task automatic do_run(input string tag, input logic [63:0] spc, input logic [63:0] hpc,
                          input logic [63:0] exp, input logic [63:0] dm, input logic [63:0] step,
                          input int abort_k, input int sneak_k, input int reset_k,
                          input bit abort_on_start);
        int n, exp_lat, e, k;
        bit halted;
        logic [63:0] pc;
        halted = 0;
        n = MAX;
        for (int j = 1; j <= MAX; j++) begin
            pc = spc + step * 64'(j - 1);
            if (pc >= hpc) begin
                n = j;
                halted = 1;
                break;
            end
        end
        exp_lat = halted ? R + n + 3 : R + n + 1;

        @(negedge CLK);
        start = 1'b1;  abort = abort_on_start;
        start_pc = spc; halt_pc = hpc; expected = exp; dmemout = dm; currentpc = spc;
        @(negedge CLK);
        e = 1;
        start = 1'b0;  abort = 1'b0;
        start_pc = ~spc; halt_pc = 64'($urandom); expected = ~exp;
        check({tag, ".startpc"}, proc_startpc, spc);
        check({tag, ".rst_busy"}, 64'(busy), 1);
        check({tag, ".rst_resetl"}, 64'(proc_resetl), 0);

        forever begin
            if (done || e > exp_lat + 4) break;
            k = e - R;
            if (k >= 1) currentpc = spc + step * 64'(k - 1);
            if (k == 1) check({tag, ".run_resetl"}, 64'(proc_resetl), 1);
            if (k >= 1 && k == sneak_k) begin
                start = 1'b1; halt_pc = 64'h0; start_pc = 64'hdead;
            end else begin
                start = 1'b0;
            end
            abort = (k >= 1 && k == abort_k);
            if (k >= 1 && k == reset_k) begin
                reset = 1'b1;
                #1;
                check_reset_vals({tag, ".async"});
                reset = 1'b0;
                return;
            end
            @(negedge CLK);
            e++;
            if (k >= 1 && k == abort_k) begin
                abort = 1'b0;
                check({tag, ".ab_done"}, 64'(done), 0);
                check({tag, ".ab_busy"}, 64'(busy), 0);
                check({tag, ".ab_resetl"}, 64'(proc_resetl), 0);
                check({tag, ".ab_pass"}, 64'(pass), 0);
                return;
            end
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(e), 64'(exp_lat));
        check({tag, ".done"}, 64'(done), 1);
        check({tag, ".pass"}, 64'(pass), 64'(halted && (dm == exp)));
        check({tag, ".timeout"}, 64'(timeout), 64'(!halted));
        check({tag, ".count"}, 64'(cycle_count), 64'(n));
        check({tag, ".resetl"}, 64'(proc_resetl), 0);
        check({tag, ".busy"}, 64'(busy), 0);
        @(negedge CLK);
        check({tag, ".hold"}, 64'({done, pass, timeout}), 64'({1'b1, halted && (dm == exp), !halted}));
    endtask

    initial begin
        logic [63:0] s, h, x, st;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        start_pc = '0; halt_pc = '0; expected = '0; currentpc = '0; dmemout = '0;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check_reset_vals("init");

        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("idle_abort.busy", 64'(busy), 0);

        do_run("basic",   64'h0,   64'h34, 64'hF, 64'hF, 64'd4, 0, 0, 0, 0);
        do_run("badcode", 64'h0,   64'h34, 64'hF, 64'hE, 64'd4, 0, 0, 0, 0);
        do_run("b2b",     64'h0,   64'h64, 64'h123456789abcdef0, 64'h123456789abcdef0,
               64'd4, 0, 0, 0, 1);
        do_run("b2b_hi",  64'h0,   64'h64, 64'h123456789abcdef0, 64'h023456789abcdef0,
               64'd4, 0, 0, 0, 0);
        do_run("halt0",   64'h100, 64'h0,  64'h5, 64'h5, 64'd4, 0, 0, 0, 0);
        do_run("stuck",   64'h10,  64'h34, 64'hF, 64'hF, 64'd0, 0, 0, 0, 0);
        do_run("edge254", 64'h0,   64'd253 * 4, 64'h1, 64'h1, 64'd4, 0, 0, 0, 0);
        do_run("edge255", 64'h0,   64'd254 * 4, 64'h1, 64'h1, 64'd4, 0, 0, 0, 0);
        do_run("sneak",   64'h0,   64'h34, 64'hF, 64'hF, 64'd4, 0, 2, 0, 0);
        do_run("abort",   64'h0,   64'h34, 64'hF, 64'hF, 64'd4, 3, 0, 0, 0);
        do_run("post_ab", 64'h0,   64'h34, 64'hF, 64'hF, 64'd4, 0, 0, 0, 0);
        do_run("reset",   64'h0,   64'h34, 64'hF, 64'hF, 64'd4, 0, 0, 5, 0);
        do_run("post_rs", 64'h40,  64'h80, 64'hA, 64'hA, 64'd8, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            s  = 64'($urandom_range(0, 255)) * 4;
            st = 64'($urandom_range(0, 8)) * 4;
            h  = s + 64'($urandom_range(0, 600));
            x  = {$urandom, $urandom};
            do_run("rand", s, h, x, ($urandom_range(0, 1) == 1) ? x : x ^ 64'h1, st,
                   0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
